// File: rtl/sign_mag_alu.sv
// Sign-magnitude add/subtract and shift-add multiply unit with a busy/done handshake.
// The operand A register is loadable; operand B is taken from sw when start is strobed.
module sign_mag_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sw,
  input  logic               load,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               select,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result_mag,
  output logic               sign,
  output logic [2*WIDTH-1:0] sel_out
);

  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    result_q;
  logic             sign_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   sum;
  logic             a_ge_b;
  logic [WIDTH-1:0] diff;
  logic [RW-1:0]    acc_next;
  logic             last_step;

  // B is sw itself on the start edge, so add/sub need no B register.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, sw};
    a_ge_b    = (a_q >= sw);
    diff      = a_ge_b ? (a_q - sw) : (sw - a_q);
    acc_next  = mplier_q[0] ? (acc_q + (RW'(mcand_q) << cnt_q)) : acc_q;
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) a_q <= sw;
          if (start) begin
            unique case (op)
              2'b00: begin
                result_q <= RW'(sum);
                sign_q   <= 1'b1;
                state_q  <= StDone;
              end
              2'b01: begin
                result_q <= RW'(diff);
                sign_q   <= a_ge_b;
                state_q  <= StDone;
              end
              2'b10: begin
                acc_q    <= '0;
                mcand_q  <= a_q;
                mplier_q <= sw;
                cnt_q    <= '0;
                state_q  <= StMul;
              end
              2'b11: begin
                result_q <= '0;
                sign_q   <= 1'b1;
                state_q  <= StDone;
              end
            endcase
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Result is published only on the DONE-entry edge, never mid-multiply.
          if (last_step) begin
            result_q <= acc_next;
            sign_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign result_mag = result_q;
  assign sign       = sign_q;
  assign sel_out    = select ? result_q : RW'(sw);

endmodule

// File: tb/tb_sign_mag_alu.sv
// Scoreboard bench: WIDTH=8 and WIDTH=16 instances share control inputs; expected
// results are queued at start and popped when each instance raises done.
module tb_sign_mag_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  sw8 = '0;
  logic [15:0] sw16 = '0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        select = 1'b0;
  logic [1:0]  op = '0;

  logic        busy8, done8, sign8;
  logic [15:0] mag8, sel8;
  logic        busy16, done16, sign16;
  logic [31:0] mag16, sel16;

  always #5 clk = ~clk;

  sign_mag_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .sw(sw8), .load(load), .start(start), .op(op),
    .select(select), .busy(busy8), .done(done8), .result_mag(mag8), .sign(sign8),
    .sel_out(sel8)
  );

  sign_mag_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .sw(sw16), .load(load), .start(start), .op(op),
    .select(select), .busy(busy16), .done(done16), .result_mag(mag16), .sign(sign16),
    .sel_out(sel16)
  );

  int n_checks = 0;
  int n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] mag;
    logic        sgn;
    int          lat;
  } exp_t;

  exp_t        q8[$];
  exp_t        q16[$];
  exp_t        e8, e16;
  logic [31:0] a8_m = '0, a16_m = '0;
  logic [31:0] last8 = '0, last16 = '0;
  int          cnt8 = 0, cnt16 = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] o, input int w);
    exp_t e;
    e.sgn = 1'b1;
    e.lat = 1;
    case (o)
      2'd0: e.mag = a + b;
      2'd1: begin
        if (a >= b) e.mag = a - b;
        else begin
          e.mag = b - a;
          e.sgn = 1'b0;
        end
      end
      2'd2: begin
        e.mag = a * b;
        e.lat = w + 1;
      end
      default: e.mag = '0;
    endcase
    return e;
  endfunction

  // Busy span, result and latency are checked at each falling edge.
  always @(negedge clk) begin
    if (busy8) begin
      cnt8 = cnt8 + 1;
      if (done8) begin
        if (q8.size() == 0) check("dut8 unexpected done", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("dut8 result_mag", 32'(mag8), e8.mag);
          check("dut8 sign", 32'(sign8), 32'(e8.sgn));
          check("dut8 busy span", cnt8, e8.lat);
          last8 = e8.mag;
        end
        cnt8 = 0;
      end else check("dut8 hold during mul", 32'(mag8), last8);
    end else cnt8 = 0;
  end

  always @(negedge clk) begin
    if (busy16) begin
      cnt16 = cnt16 + 1;
      if (done16) begin
        if (q16.size() == 0) check("dut16 unexpected done", 32'd1, 32'd0);
        else begin
          e16 = q16.pop_front();
          check("dut16 result_mag", mag16, e16.mag);
          check("dut16 sign", 32'(sign16), 32'(e16.sgn));
          check("dut16 busy span", cnt16, e16.lat);
          last16 = e16.mag;
        end
        cnt16 = 0;
      end else check("dut16 hold during mul", mag16, last16);
    end else cnt16 = 0;
  end

  // Entered and left at posedge+1; inputs are sampled by the next rising edge.
  task automatic drive(input logic l, input logic s, input logic [1:0] o,
                       input logic [7:0] v8, input logic [15:0] v16, input logic accept);
    load  = l;
    start = s;
    op    = o;
    sw8   = v8;
    sw16  = v16;
    if (accept) begin
      if (s) begin
        q8.push_back(model(a8_m, 32'(v8), o, 8));
        q16.push_back(model(a16_m, 32'(v16), o, 16));
      end
      if (l) begin
        a8_m  = 32'(v8);
        a16_m = 32'(v16);
      end
    end
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy8 || busy16) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy8 || busy16) check("wait idle timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy8"}, 32'(busy8), 32'd0);
    check({tag, " done8"}, 32'(done8), 32'd0);
    check({tag, " mag8"}, 32'(mag8), 32'd0);
    check({tag, " sign8"}, 32'(sign8), 32'd1);
    check({tag, " busy16"}, 32'(busy16), 32'd0);
    check({tag, " mag16"}, mag16, 32'd0);
    check({tag, " sign16"}, 32'(sign16), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Add 200 + 100.
    drive(1'b1, 1'b0, 2'd0, 8'd200, 16'd200, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 8'd100, 16'd100, 1'b1);
    wait_idle();

    // Subtract: negative result, then equal operands.
    drive(1'b1, 1'b0, 2'd0, 8'd10, 16'd10, 1'b1);
    drive(1'b0, 1'b1, 2'd1, 8'd20, 16'd20, 1'b1);
    wait_idle();
    drive(1'b1, 1'b0, 2'd0, 8'd20, 16'd20, 1'b1);
    drive(1'b0, 1'b1, 2'd1, 8'd20, 16'd20, 1'b1);
    wait_idle();

    // Clear after a nonzero result.
    drive(1'b0, 1'b1, 2'd0, 8'd5, 16'd5, 1'b1);
    wait_idle();
    drive(1'b0, 1'b1, 2'd3, 8'd99, 16'd99, 1'b1);
    wait_idle();

    // Max multiply, with load/start pulsed while busy.
    drive(1'b1, 1'b0, 2'd0, 8'd255, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 8'd255, 16'hFFFF, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b1, 2'd0, 8'd7, 16'd7, 1'b0);
    wait_idle();
    // A must still be the max value.
    drive(1'b0, 1'b1, 2'd0, 8'd0, 16'd0, 1'b1);
    wait_idle();

    // 0 * 255 and 1 * 128.
    drive(1'b1, 1'b0, 2'd0, 8'd0, 16'd0, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 8'd255, 16'd255, 1'b1);
    wait_idle();
    drive(1'b1, 1'b0, 2'd0, 8'd1, 16'd1, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 8'd128, 16'd128, 1'b1);
    wait_idle();

    // Reset in the middle of a multiply.
    drive(1'b1, 1'b0, 2'd0, 8'd255, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 8'd255, 16'hFFFF, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b0;
    q8.delete();
    q16.delete();
    a8_m   = '0;
    a16_m  = '0;
    last8  = '0;
    last16 = '0;
    #1;
    check_reset_state("mid-mul reset");
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 2'd0, 8'd3, 16'd3, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 8'd4, 16'd4, 1'b1);
    wait_idle();

    // Display mux.
    sw8    = 8'h5A;
    sw16   = 16'h005A;
    select = 1'b0;
    #1;
    check("sel8 sw", 32'(sel8), 32'h5A);
    check("sel16 sw", sel16, 32'h5A);
    select = 1'b1;
    #1;
    check("sel8 result", 32'(sel8), last8);
    check("sel16 result", sel16, last16);
    select = 1'b0;
    @(posedge clk);
    #1;

    // load and start together: operation uses the old A.
    drive(1'b1, 1'b1, 2'd0, 8'd10, 16'd10, 1'b1);
    wait_idle();
    drive(1'b0, 1'b1, 2'd0, 8'd5, 16'd5, 1'b1);
    wait_idle();

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 2'd0, 8'($urandom), 16'($urandom), 1'b1);
      drive(1'b0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom), 1'b1);
      wait_idle();
    end

    @(posedge clk);
    #1;
    check("dut8 queue drained", q8.size(), 32'd0);
    check("dut16 queue drained", q16.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
